// File: rtl/shot_score_keeper.sv
// Round controller for the shooting game: gates shots, tracks shots/hits/score,
// requests new targets and declares win or loss. Optional macro: STREAK_BONUS_EN.
module shot_score_keeper #(
  parameter int unsigned SHOTS_PER_ROUND = 8,
  parameter int unsigned WIN_HITS        = 5,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned TIMEOUT_CYC     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               start_new_game,
  input  logic               shoot_req,
  input  logic               result_valid,
  input  logic               hit,
  output logic               fire_ok,
  output logic               new_target,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         shots_left,
  output logic [3:0]         hits,
  output logic [1:0]         streak,
  output logic               game_active,
  output logic               game_over,
  output logic               game_won
);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_IN_FLIGHT, S_RESOLVE, S_OVER} state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         shots_left_q, shots_left_d;
  logic [3:0]         hits_q, hits_d;
  logic [7:0]         timeout_cnt_q, timeout_cnt_d;
  logic               pending_hit_q, pending_hit_d;
  logic               new_target_q, new_target_d;
  logic               game_won_q, game_won_d;
`ifdef STREAK_BONUS_EN
  logic [1:0]         streak_q, streak_d;
`endif

  logic               start_edge, fire, timeout, win_reached;
  logic [3:0]         hits_upd;
  logic [2:0]         points;
  logic [SCORE_W+2:0] score_sum;

  assign start_d     = start_new_game;
  assign start_edge  = start_new_game & ~start_q;
  // A start edge pre-empts a coincident shot request.
  assign fire        = (state_q == S_READY) && shoot_req && (shots_left_q != 4'd0) && !start_edge;
  assign timeout     = timeout_cnt_q == 8'(TIMEOUT_CYC - 1);
  assign hits_upd    = hits_q + {3'd0, pending_hit_q};
  assign win_reached = hits_upd >= 4'(WIN_HITS);

`ifdef STREAK_BONUS_EN
  assign points = 3'd1 + {1'b0, streak_q};
`else
  assign points = 3'd1;
`endif
  assign score_sum = {3'b000, score_q} + {{SCORE_W{1'b0}}, points};

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      score_q       <= '0;
      shots_left_q  <= '0;
      hits_q        <= '0;
      timeout_cnt_q <= '0;
      pending_hit_q <= 1'b0;
      new_target_q  <= 1'b0;
      game_won_q    <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak_q      <= '0;
`endif
    end else if (ena) begin
      state_q       <= state_d;
      start_q       <= start_d;
      score_q       <= score_d;
      shots_left_q  <= shots_left_d;
      hits_q        <= hits_d;
      timeout_cnt_q <= timeout_cnt_d;
      pending_hit_q <= pending_hit_d;
      new_target_q  <= new_target_d;
      game_won_q    <= game_won_d;
`ifdef STREAK_BONUS_EN
      streak_q      <= streak_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: state_d = state_q;
      S_READY:        if (fire) state_d = S_IN_FLIGHT;
      S_IN_FLIGHT:    if (result_valid || timeout) state_d = S_RESOLVE;
      S_RESOLVE:      state_d = (win_reached || shots_left_q == 4'd0) ? S_OVER : S_READY;
      default:        state_d = S_IDLE;
    endcase
    if (start_edge) state_d = S_READY;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    score_d       = score_q;
    shots_left_d  = shots_left_q;
    hits_d        = hits_q;
    timeout_cnt_d = timeout_cnt_q;
    pending_hit_d = pending_hit_q;
    new_target_d  = 1'b0;
    game_won_d    = game_won_q;
`ifdef STREAK_BONUS_EN
    streak_d      = streak_q;
`endif
    if (start_edge) begin
      shots_left_d  = 4'(SHOTS_PER_ROUND);
      score_d       = '0;
      hits_d        = '0;
      timeout_cnt_d = '0;
      pending_hit_d = 1'b0;
      game_won_d    = 1'b0;
`ifdef STREAK_BONUS_EN
      streak_d      = '0;
`endif
    end else begin
      case (state_q)
        S_READY: begin
          if (fire) begin
            shots_left_d  = shots_left_q - 4'd1;
            timeout_cnt_d = '0;
          end
        end
        S_IN_FLIGHT: begin
          timeout_cnt_d = timeout_cnt_q + 8'd1;
          if (result_valid)  pending_hit_d = hit;
          else if (timeout)  pending_hit_d = 1'b0;
        end
        S_RESOLVE: begin
          hits_d     = hits_upd;
          game_won_d = win_reached;
          if (pending_hit_q) begin
            score_d      = (score_sum > {3'b000, {SCORE_W{1'b1}}}) ? '1 : score_sum[SCORE_W-1:0];
            new_target_d = 1'b1;
`ifdef STREAK_BONUS_EN
            if (streak_q != 2'd3) streak_d = streak_q + 2'd1;
          end else begin
            streak_d = '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign fire_ok     = ena & fire;
  assign new_target  = ena & new_target_q;
  assign score       = score_q;
  assign shots_left  = shots_left_q;
  assign hits        = hits_q;
  assign game_active = (state_q == S_READY) || (state_q == S_IN_FLIGHT);
  assign game_over   = state_q == S_OVER;
  assign game_won    = game_won_q;
`ifdef STREAK_BONUS_EN
  assign streak      = streak_q;
`else
  assign streak      = 2'b00;
`endif

endmodule

// File: tb/tb_shot_score_keeper.sv
// Randomized scoreboard bench for shot_score_keeper: a game-level reference model
// queues expected pulses and snapshots; a negedge monitor pops and compares them.
module tb_shot_score_keeper;

  localparam int SHOTS     = 10;
  localparam int WIN       = 8;
  localparam int SW        = 3;
  localparam int TO        = 12;
  localparam int SCORE_MAX = (1 << SW) - 1;
`ifdef STREAK_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  typedef enum int {P_IDLE, P_PLAY, P_OVER} phase_t;
  typedef enum int {K_HIT, K_MISS, K_TIMEOUT, K_RESTART, K_RESET} kind_t;
  typedef struct {
    int cyc;
    int score;
    int shots;
    int hits;
    int streak;
    bit active;
    bit over;
    bit won;
  } snap_t;

  logic          clk = 1'b0;
  logic          reset, ena, start_new_game, shoot_req, result_valid, hit;
  logic          fire_ok, new_target, game_active, game_over, game_won;
  logic [SW-1:0] score;
  logic [3:0]    shots_left, hits;
  logic [1:0]    streak;

  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     fire_q[$];
  int     nt_q[$];
  snap_t  snap_q[$];

  phase_t phase = P_IDLE;
  int     m_score = 0, m_shots = 0, m_hits = 0, m_streak = 0;
  bit     m_won = 1'b0;
  int     hit_pct = 50;
  bit     allow_restart = 1'b0;

  shot_score_keeper #(
    .SHOTS_PER_ROUND(SHOTS),
    .WIN_HITS       (WIN),
    .SCORE_W        (SW),
    .TIMEOUT_CYC    (TO)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .ena           (ena),
    .start_new_game(start_new_game),
    .shoot_req     (shoot_req),
    .result_valid  (result_valid),
    .hit           (hit),
    .fire_ok       (fire_ok),
    .new_target    (new_target),
    .score         (score),
    .shots_left    (shots_left),
    .hits          (hits),
    .streak        (streak),
    .game_active   (game_active),
    .game_over     (game_over),
    .game_won      (game_won)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string what);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s", what);
    end
  endtask

  task automatic push_snap(input int c);
    snap_t s;
    s.cyc    = c;
    s.score  = m_score;
    s.shots  = m_shots;
    s.hits   = m_hits;
    s.streak = m_streak;
    s.active = (phase == P_PLAY);
    s.over   = (phase == P_OVER);
    s.won    = m_won;
    snap_q.push_back(s);
  endtask

  // Game-level rules applied when a shot's outcome is known.
  task automatic model_resolve(input bit was_hit);
    if (was_hit) begin
      m_score  = m_score + (BONUS ? 1 + m_streak : 1);
      if (m_score > SCORE_MAX) m_score = SCORE_MAX;
      m_hits++;
      m_streak = BONUS ? ((m_streak + 1 > 3) ? 3 : m_streak + 1) : 0;
    end else begin
      m_streak = 0;
    end
    if (m_hits >= WIN) begin
      phase = P_OVER;
      m_won = 1'b1;
    end else if (m_shots == 0) begin
      phase = P_OVER;
      m_won = 1'b0;
    end
  endtask

  always @(negedge clk) begin : monitor
    snap_t e;
    bit    ok;
    if (fire_q.size() > 0 && fire_q[0] == cyc) begin
      void'(fire_q.pop_front());
      check(fire_ok === 1'b1, $sformatf("fire_ok cyc=%0d got %b expected 1", cyc, fire_ok));
    end else begin
      check(fire_ok === 1'b0, $sformatf("fire_ok cyc=%0d got %b expected 0", cyc, fire_ok));
    end
    if (nt_q.size() > 0 && nt_q[0] == cyc) begin
      void'(nt_q.pop_front());
      check(new_target === 1'b1, $sformatf("new_target cyc=%0d got %b expected 1", cyc, new_target));
    end else begin
      check(new_target === 1'b0, $sformatf("new_target cyc=%0d got %b expected 0", cyc, new_target));
    end
    while (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      e  = snap_q.pop_front();
      ok = !$isunknown({score, shots_left, hits, streak, game_active, game_over, game_won}) &&
           int'(score) == e.score && int'(shots_left) == e.shots && int'(hits) == e.hits &&
           int'(streak) == e.streak && game_active == e.active && game_over == e.over &&
           game_won == e.won;
      check(ok, $sformatf("snapshot cyc=%0d got score=%0d shots=%0d hits=%0d streak=%0d act=%b over=%b won=%b expected score=%0d shots=%0d hits=%0d streak=%0d act=%b over=%b won=%b",
            cyc, score, shots_left, hits, streak, game_active, game_over, game_won,
            e.score, e.shots, e.hits, e.streak, e.active, e.over, e.won));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input bit junk);
    reset          = 1'b0;
    ena            = 1'b1;
    start_new_game = 1'b1;
    shoot_req      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    result_valid   = junk;
    hit            = 1'($urandom_range(0, 1));
    phase    = P_PLAY;
    m_score  = 0;
    m_shots  = SHOTS;
    m_hits   = 0;
    m_streak = 0;
    m_won    = 1'b0;
    push_snap(cyc + 1);
    tick();
    start_new_game = 1'b0;
    shoot_req      = 1'b0;
    result_valid   = 1'b0;
  endtask

  // First cycle keeps ena high so a pending new_target pulse is never masked.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      ena          = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      result_valid = 1'($urandom_range(0, 1));
      hit          = 1'($urandom_range(0, 1));
      shoot_req    = (!ena || phase != P_PLAY) ? 1'($urandom_range(0, 1)) : 1'b0;
      push_snap(cyc);
      tick();
    end
    ena          = 1'b1;
    shoot_req    = 1'b0;
    result_valid = 1'b0;
  endtask

  task automatic shot(input int force_kind);
    int    d, r;
    kind_t kind;
    bit    accepted;
    ena      = 1'b1;
    accepted = (phase == P_PLAY) && (m_shots > 0);
    shoot_req = 1'b1;
    if (accepted) fire_q.push_back(cyc);
    tick();
    shoot_req = 1'b0;
    if (!accepted) return;
    m_shots--;

    if (force_kind >= 0) kind = kind_t'(force_kind);
    else if (allow_restart && $urandom_range(0, 39) == 0) kind = K_RESTART;
    else begin
      r    = $urandom_range(0, 99);
      kind = (r < hit_pct) ? K_HIT : (r[0] ? K_MISS : K_TIMEOUT);
    end
    d = (kind == K_TIMEOUT) ? TO - 1 : $urandom_range(0, TO - 1);

    for (int i = 0; i < d; i++) begin
      shoot_req    = 1'($urandom_range(0, 1));
      result_valid = 1'b0;
      tick();
    end
    shoot_req = 1'b0;

    if (kind == K_RESTART) begin
      start_game(1'b1);
      return;
    end
    if (kind == K_RESET) begin
      reset        = 1'b1;
      ena          = 1'b0;
      result_valid = 1'b1;
      shoot_req    = 1'b1;
      phase    = P_IDLE;
      m_score  = 0;
      m_shots  = 0;
      m_hits   = 0;
      m_streak = 0;
      m_won    = 1'b0;
      push_snap(cyc + 1);
      tick();
      reset        = 1'b0;
      ena          = 1'b1;
      result_valid = 1'b0;
      shoot_req    = 1'b0;
      return;
    end

    result_valid = (kind != K_TIMEOUT);
    hit          = (kind == K_HIT);
    tick();
    result_valid = 1'($urandom_range(0, 1));
    hit          = 1'($urandom_range(0, 1));
    model_resolve(kind == K_HIT);
    push_snap(cyc + 1);
    if (kind == K_HIT) nt_q.push_back(cyc + 1);
    tick();
    result_valid = 1'b0;
  endtask

  task automatic play_game(input int force_kind);
    int guard = 0;
    start_game(1'b0);
    gap(2);
    while (phase == P_PLAY && guard < 60) begin
      shot(force_kind);
      gap($urandom_range(1, 3));
      guard++;
    end
    gap(4);
    shot(-1);
    gap(1);
  endtask

  initial begin
    reset          = 1'b1;
    ena            = 1'b1;
    start_new_game = 1'b0;
    shoot_req      = 1'b0;
    result_valid   = 1'b0;
    hit            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    gap(4);
    shot(-1);
    gap(1);

    allow_restart = 1'b0;
    play_game(int'(K_HIT));
    hit_pct = 0;
    play_game(-1);

    allow_restart = 1'b1;
    for (int g = 0; g < 6; g++) begin
      hit_pct = $urandom_range(40, 95);
      play_game(-1);
    end

    allow_restart = 1'b0;
    start_game(1'b0);
    gap(2);
    shot(int'(K_HIT));
    gap(1);
    shot(int'(K_RESTART));
    gap(2);
    shot(int'(K_RESET));
    gap(3);
    shot(-1);
    gap(1);
    start_game(1'b0);
    gap(1);
    shot(int'(K_TIMEOUT));
    gap(2);

    repeat (3) tick();
    check(fire_q.size() == 0, $sformatf("fire_queue_drained got %0d left expected 0", fire_q.size()));
    check(nt_q.size() == 0, $sformatf("new_target_queue_drained got %0d left expected 0", nt_q.size()));
    check(snap_q.size() == 0, $sformatf("snapshot_queue_drained got %0d left expected 0", snap_q.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d expected completion before time limit", cyc);
    $fatal(1);
  end

endmodule

// File: doc/shot_score_keeper.md
Name: shot_score_keeper

Overview:
- Downstream consumer of the trajectory calculator's per-shot result (result_valid/hit pulse pair).
- Runs the round state machine:
  - gates new shots
  - counts remaining shots and hits
  - accumulates score with streak bonus
  - requests a fresh target after each hit
  - declares win or loss
- Outputs feed the top-level display mux and the target generator.

Parameters:
- SHOTS_PER_ROUND, 8: shots granted per game; legal 1..15.
- WIN_HITS, 5: hits needed to win; legal 1..15.
- SCORE_W, 8: score register width.
- TIMEOUT_CYC, 64: cycles waited for result_valid before the shot is scored as a miss; legal 2..255.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- ena, input, 1: design enable. When low, every register holds, including the edge detector.
- start_new_game, input, 1: level from the control stage; its rising edge starts a game.
- shoot_req, input, 1: one-cycle shot request from the control stage.
- result_valid, input, 1: one-cycle pulse marking the end of a shot evaluation.
- hit, input, 1: hit flag, sampled only when result_valid=1.
- fire_ok, output, 1: one-cycle pulse when a shot is accepted; drives the trajectory calculator's shoot input.
- new_target, output, 1: one-cycle pulse after a hit; drives the target generator.
- score, output, SCORE_W: accumulated score.
- shots_left, output, 4: remaining shots.
- hits, output, 4: hits this game.
- streak, output, 2: consecutive hit count, saturating at 3.
- game_active, output, 1: high in READY and IN_FLIGHT.
- game_over, output, 1: high in OVER.
- game_won, output, 1: valid while game_over=1.

Behaviour:
- Reset value of every output and register:
  - state=IDLE
  - score=0, shots_left=0, hits=0, streak=0
  - all pulses 0
  - game_won=0
  - timeout counter=0
  - start edge register=0
- Start edge: a rising edge of start_new_game is (start_new_game & ~start_q), with start_q registered each enabled cycle.
- States:
  - IDLE: waits for a start edge.
  - READY: waits for shoot_req.
  - IN_FLIGHT: waits for result_valid or timeout.
  - RESOLVE: one cycle, applies the result.
  - OVER: holds the final values until a start edge.
- Start edge in any state, same cycle:
  - next state READY
  - shots_left=SHOTS_PER_ROUND
  - score=0, hits=0, streak=0, game_won=0
  - timeout counter cleared
  - a coincident result_valid or shoot_req is dropped
- READY with shoot_req=1 and shots_left>0:
  - fire_ok=1 for that cycle
  - shots_left decrements by 1
  - timeout counter cleared
  - next state IN_FLIGHT
- shoot_req outside READY, or with shots_left=0: ignored, fire_ok stays 0.
- IN_FLIGHT:
  - the timeout counter increments each enabled cycle.
  - result_valid=1 latches hit into pending_hit; next state RESOLVE.
  - counter reaching TIMEOUT_CYC-1 without result_valid sets pending_hit=0; next state RESOLVE.
  - result_valid wins if it coincides with timeout.
- result_valid outside IN_FLIGHT: ignored.
- RESOLVE on a hit:
  - score += points, saturating at 2^SCORE_W-1.
  - hits += 1.
  - streak = min(streak+1, 3).
  - new_target=1 for that cycle.
- RESOLVE on a miss: streak=0; score unchanged.
- RESOLVE next state, checked in priority order:
  1. hits (updated) >= WIN_HITS: OVER with game_won=1.
  2. else shots_left=0: OVER with game_won=0.
  3. else READY.
- Latency:
  - shoot_req to fire_ok: 0 cycles (combinational from state and registered counters).
  - result_valid to score/new_target update: 2 cycles (latch, then RESOLVE registered outputs).
- All outputs are registered except fire_ok.
- ena=0: fire_ok=0 and new_target=0 are forced; state holds; pulses missed while disabled are lost.
- Reset asserted mid-flight: returns to IDLE next edge regardless of other inputs.

Optional Feature:
- Macro: STREAK_BONUS_EN.
- Defined: a hit scores points = 1 + streak, using the streak value before the increment (1,2,3,4,4,...).
- Undefined: every hit scores 1; the streak register is removed and the streak output is tied to 0.

Test Plan:
- Reset, then start edge → state READY, shots_left=8, score=0, game_active=1; one cycle later fire_ok stays 0 until shoot_req.
- shoot_req, then result_valid=1 with hit=1, three times (bonus enabled) → score 1,3,6; streak 1,2,3; new_target pulses 3 times; shots_left=5.
- shoot_req with no result_valid for 64 cycles → RESOLVE as miss, streak=0, score unchanged, shots_left decremented, back to READY.
- 8 shots all missed → game_over=1, game_won=0, shots_left=0; further shoot_req yields no fire_ok.
- 5 hits within 8 shots → game_over=1, game_won=1 on the fifth RESOLVE.
- Start edge coincident with result_valid while IN_FLIGHT → result dropped, counters reinitialised, shots_left=8.
- SCORE_W=3, repeated hits → score saturates at 7.
